xif_mem_responder: RTL and testbench
====================================

Name: xif_mem_responder

Overview:
- Core-side responder for the CV-X-IF memory request/result interface.
- Accepts load/store requests issued by the FP subsystem (x_mem_valid/ready), performs each as one OBI data-bus transaction, and returns x_mem_result carrying the originating instruction id.
- Sits between the coprocessor memory port and the core data-bus arbiter; in-order, non-speculative.

Parameters:
- MAX_OUTSTANDING, 2, granted-but-unanswered OBI transactions tracked (depth of id FIFO, >=1).
- X_ID_WIDTH, 4, instruction id width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- x_mem_valid_i  in  1  coprocessor memory request valid
- x_mem_ready_o  out  1  request accepted when valid&ready
- x_mem_req_addr_i  in  32  byte address
- x_mem_req_we_i  in  1  1=store, 0=load
- x_mem_req_be_i  in  4  byte enables
- x_mem_req_wdata_i  in  32  store data
- x_mem_req_id_i  in  X_ID_WIDTH  instruction id
- x_mem_req_last_i  in  1  last access of instruction (always 1 from current FPU SS; ignored)
- x_mem_req_spec_i  in  1  speculative flag (must be 0)
- x_mem_result_valid_o  out  1  result valid (no ready; consumer must accept)
- x_mem_result_id_o  out  X_ID_WIDTH  id of completing access
- x_mem_result_rdata_o  out  32  load data
- x_mem_result_err_o  out  1  bus error
- data_req_o  out  1  OBI request
- data_gnt_i  in  1  OBI grant
- data_addr_o  out  32  OBI address
- data_we_o  out  1  OBI write enable
- data_be_o  out  4  OBI byte enables
- data_wdata_o  out  32  OBI write data
- data_rvalid_i  in  1  OBI response valid
- data_rdata_i  in  32  OBI read data
- data_err_i  in  1  OBI error

Behaviour:
- Reset: state IDLE, FIFO empty. All outputs 0: x_mem_ready_o, data_req_o, x_mem_result_valid_o, and all data/id/err outputs.
- FSM, two states:
  - IDLE: x_mem_ready_o = (count < MAX_OUTSTANDING). On handshake, latch addr/we/be/wdata/id and go to REQ.
  - REQ: data_req_o=1. Latched fields drive data_* and stay stable until grant. x_mem_ready_o=0. On data_gnt_i, push latched id into FIFO and go to IDLE.
- Latency and throughput:
  - Handshake at cycle N → data_req_o high at N+1.
  - Zero-wait grant → one accepted request every 2 cycles.
- Response path:
  - data_rvalid_i at cycle M → x_mem_result_valid_o=1 at M+1 (registered).
  - rdata, err and the FIFO-head id are registered alongside. FIFO pops at M.
  - For stores, rdata_o is passed as-is; the consumer ignores it.
- Ordering: OBI responses arrive in grant order, so FIFO order equals result order.
- Counting:
  - count = FIFO occupancy. Acceptance is gated so count never exceeds MAX_OUTSTANDING.
  - Push and pop in the same cycle: count unchanged.
  - FIFO full in IDLE: ready held 0 until a pop; ready rises the cycle after the pop.
- Grant while rvalid for an older access: both are handled in the same cycle.
- data_rvalid_i with FIFO empty is a protocol violation: ignored (no result, no pop), flagged by assertion.
- x_mem_req_spec_i=1 is a protocol violation: flagged by assertion, and the request is treated as non-speculative.
- x_mem_valid_i may drop without a handshake; no state change.
- Reset mid-operation: asynchronous clear. The in-flight request and outstanding ids are dropped, and no result is produced for them.
- Pointer wrap: FIFO read/write pointers wrap modulo MAX_OUTSTANDING. count is one bit wider than the pointers.

Decomposition:
- State enum (IDLE, REQ) goes in a shared package, cv32e40p_core_v_xif_pkg. Existing x_mem request/result types there are reused for the latched request and the registered result.
- Sub-module xif_mem_id_fifo: parameterised id FIFO (depth, width) with push/pop/full/empty/count, async active-low reset.

Test Plan:
- Single load: request addr 0x1000, we=0, id=3; gnt at once, rvalid 2 cycles later with rdata 0xDEADBEEF → data_req_o high for exactly 1 cycle at addr 0x1000; result_valid=1 for 1 cycle, id=3, rdata=0xDEADBEEF, err=0.
- Store with grant stall: we=1, be=0xF, wdata 0x12345678, gnt held low for 4 cycles → data_req_o and all data_* stable for 5 cycles, x_mem_ready_o=0 throughout; on rvalid, result id matches the request.
- Back-to-back fill, MAX_OUTSTANDING=2: two loads (ids 1, 2) granted, rvalid withheld → x_mem_ready_o=0 with a third valid pending; first rvalid → ready=1 the next cycle, result ids returned in order 1 then 2.
- Simultaneous grant and response: grant of id 5 in the same cycle as rvalid for id 4 → result id=4, count unchanged, id 5 returned on the next rvalid.
- Error response: rvalid with data_err_i=1 → result err=1 with the correct id; next access has err=0.
- Reset mid-transaction: rst_ni low during REQ with one id outstanding → all outputs 0 immediately; after release ready=1, and a late rvalid produces no result.

Source files
------------

// File: rtl/cv32e40p_core_v_xif_pkg.sv
// Shared CV-X-IF memory-interface types: responder FSM states plus the
// latched request and registered result payloads.
package cv32e40p_core_v_xif_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } xif_mem_state_e;

  // Request fields carried from the X-IF handshake to the OBI address phase.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } x_mem_req_t;

  // Response fields captured from the OBI response phase.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } x_mem_result_t;

endpackage

// File: rtl/xif_mem_id_fifo.sv
// Small circular FIFO holding the instruction ids of granted OBI accesses
// whose responses are still pending. Pointers wrap modulo DEPTH.
module xif_mem_id_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointer and occupancy; simultaneous push and pop leave count unchanged.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    if (wr_en) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Id storage.
  // NOTE: storage is left unreset; an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/xif_mem_responder.sv
// CV-X-IF memory responder: turns each accepted x_mem request into one OBI
// data-bus transaction and returns the response tagged with its instruction id.
module xif_mem_responder
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int X_ID_WIDTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  x_mem_valid_i,
  output logic                  x_mem_ready_o,
  input  logic [31:0]           x_mem_req_addr_i,
  input  logic                  x_mem_req_we_i,
  input  logic [3:0]            x_mem_req_be_i,
  input  logic [31:0]           x_mem_req_wdata_i,
  input  logic [X_ID_WIDTH-1:0] x_mem_req_id_i,
  input  logic                  x_mem_req_last_i,
  input  logic                  x_mem_req_spec_i,
  output logic                  x_mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0] x_mem_result_id_o,
  output logic [31:0]           x_mem_result_rdata_o,
  output logic                  x_mem_result_err_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i
);

  localparam int CW = ((MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1) + 1;

  xif_mem_state_e        state_q, state_d;
  x_mem_req_t            req_q, req_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic                  ready_q, ready_d;
  logic                  data_req_q, data_req_d;
  x_mem_result_t         res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic [X_ID_WIDTH-1:0] res_id_q, res_id_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [X_ID_WIDTH-1:0] fifo_head;
  logic [CW-1:0]         fifo_count, count_nxt;
  logic                  handshake;
  logic                  unused_inputs;

  // The current FPU SS always sets last; spec is only checked by assertion.
  assign unused_inputs = x_mem_req_last_i ^ x_mem_req_spec_i;

  assign handshake = x_mem_valid_i && ready_q;
  assign fifo_push = (state_q == REQ) && data_gnt_i;
  assign fifo_pop  = data_rvalid_i && !fifo_empty;
  assign count_nxt = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

  xif_mem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (X_ID_WIDTH)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (id_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state, latched request and registered-output values.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = REQ;
          req_d   = '{addr: x_mem_req_addr_i, we: x_mem_req_we_i,
                      be: x_mem_req_be_i, wdata: x_mem_req_wdata_i};
          id_d    = x_mem_req_id_i;
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    data_req_d = (state_d == REQ);
    // Looking at next-cycle occupancy makes ready rise the cycle after a pop.
    ready_d    = (state_d == IDLE) && (count_nxt < CW'(MAX_OUTSTANDING));

    res_valid_d = fifo_pop;
    res_d       = res_q;
    res_id_d    = res_id_q;
    if (fifo_pop) begin
      res_d    = '{rdata: data_rdata_i, err: data_err_i};
      res_id_d = fifo_head;
    end
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      id_q        <= '0;
      ready_q     <= 1'b0;
      data_req_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      id_q        <= id_d;
      ready_q     <= ready_d;
      data_req_q  <= data_req_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
    end
  end

  assign x_mem_ready_o        = ready_q;
  assign data_req_o           = data_req_q;
  assign data_addr_o          = req_q.addr;
  assign data_we_o            = req_q.we;
  assign data_be_o            = req_q.be;
  assign data_wdata_o         = req_q.wdata;
  assign x_mem_result_valid_o = res_valid_q;
  assign x_mem_result_id_o    = res_id_q;
  assign x_mem_result_rdata_o = res_q.rdata;
  assign x_mem_result_err_o   = res_q.err;

  // Protocol checks on the two neighbouring interfaces.
  a_rvalid_has_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> !fifo_empty)
    else $error("xif_mem_responder: data_rvalid_i with no outstanding access");

  a_no_speculative_req: assert property (
    @(posedge clk_i) disable iff (!rst_ni) handshake |-> !x_mem_req_spec_i)
    else $error("xif_mem_responder: speculative memory request accepted");

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) fifo_push |-> !fifo_full)
    else $error("xif_mem_responder: id FIFO overflow");

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed bench for xif_mem_responder with a queue-based result scoreboard.
module tb_xif_mem_responder;

  localparam int IDW = 4;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            x_mem_valid_i;
  logic            x_mem_ready_o;
  logic [31:0]     x_mem_req_addr_i;
  logic            x_mem_req_we_i;
  logic [3:0]      x_mem_req_be_i;
  logic [31:0]     x_mem_req_wdata_i;
  logic [IDW-1:0]  x_mem_req_id_i;
  logic            x_mem_req_last_i;
  logic            x_mem_req_spec_i;
  logic            x_mem_result_valid_o;
  logic [IDW-1:0]  x_mem_result_id_o;
  logic [31:0]     x_mem_result_rdata_o;
  logic            x_mem_result_err_o;
  logic            data_req_o;
  logic            data_gnt_i;
  logic [31:0]     data_addr_o;
  logic            data_we_o;
  logic [3:0]      data_be_o;
  logic [31:0]     data_wdata_o;
  logic            data_rvalid_i;
  logic [31:0]     data_rdata_i;
  logic            data_err_i;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    rdata;
    logic           err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic gnt_en = 1'b1;

  always #5 clk = ~clk;

  xif_mem_responder #(.MAX_OUTSTANDING(2), .X_ID_WIDTH(IDW)) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .x_mem_valid_i        (x_mem_valid_i),
    .x_mem_ready_o        (x_mem_ready_o),
    .x_mem_req_addr_i     (x_mem_req_addr_i),
    .x_mem_req_we_i       (x_mem_req_we_i),
    .x_mem_req_be_i       (x_mem_req_be_i),
    .x_mem_req_wdata_i    (x_mem_req_wdata_i),
    .x_mem_req_id_i       (x_mem_req_id_i),
    .x_mem_req_last_i     (x_mem_req_last_i),
    .x_mem_req_spec_i     (x_mem_req_spec_i),
    .x_mem_result_valid_o (x_mem_result_valid_o),
    .x_mem_result_id_o    (x_mem_result_id_o),
    .x_mem_result_rdata_o (x_mem_result_rdata_o),
    .x_mem_result_err_o   (x_mem_result_err_o),
    .data_req_o           (data_req_o),
    .data_gnt_i           (data_gnt_i),
    .data_addr_o          (data_addr_o),
    .data_we_o            (data_we_o),
    .data_be_o            (data_be_o),
    .data_wdata_o         (data_wdata_o),
    .data_rvalid_i        (data_rvalid_i),
    .data_rdata_i         (data_rdata_i),
    .data_err_i           (data_err_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Grant responder: grants any pending request while gnt_en is set.
  initial begin
    data_gnt_i = 1'b0;
    forever begin
      @(negedge clk);
      data_gnt_i = data_req_o && gnt_en;
    end
  end

  // Monitor: every presented result must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (x_mem_result_valid_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 64'(x_mem_result_id_o), 64'hFFFF);
        end else begin
          mon_e = sb_q.pop_front();
          check("result_id", 64'(x_mem_result_id_o), 64'(mon_e.id));
          check("result_rdata", 64'(x_mem_result_rdata_o), 64'(mon_e.rdata));
          check("result_err", 64'(x_mem_result_err_o), 64'(mon_e.err));
        end
      end
    end
  end

  // Present a request and hold it until the handshake edge has passed.
  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [IDW-1:0] id);
    bit done = 1'b0;
    @(negedge clk);
    x_mem_req_addr_i  = addr;
    x_mem_req_we_i    = we;
    x_mem_req_be_i    = be;
    x_mem_req_wdata_i = wdata;
    x_mem_req_id_i    = id;
    x_mem_valid_i     = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (x_mem_ready_o) done = 1'b1;
    end
    if (!done) check("issue_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
    x_mem_valid_i = 1'b0;
  endtask

  // One-cycle OBI response; the expected result is queued at the same time.
  task automatic respond(input logic [31:0] rdata, input logic err, input logic [IDW-1:0] exp_id);
    exp_t e;
    @(negedge clk);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    data_err_i    = err;
    e.id = exp_id; e.rdata = rdata; e.err = err;
    sb_q.push_back(e);
    @(negedge clk);
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    x_mem_valid_i = 1'b0; x_mem_req_addr_i = '0; x_mem_req_we_i = 1'b0;
    x_mem_req_be_i = '0; x_mem_req_wdata_i = '0; x_mem_req_id_i = '0;
    x_mem_req_last_i = 1'b1; x_mem_req_spec_i = 1'b0;
    data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;

    // Reset state.
    #12;
    check("rst_ready", 64'(x_mem_ready_o), 64'd0);
    check("rst_req", 64'(data_req_o), 64'd0);
    check("rst_result_valid", 64'(x_mem_result_valid_o), 64'd0);
    check("rst_data_bus", {data_addr_o, data_we_o, data_be_o, data_wdata_o[26:0]}, 64'd0);
    check("rst_result", {x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o}, 64'd0);
    #10 rst_ni = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(x_mem_ready_o), 64'd1);

    // Single load with immediate grant.
    issue(32'h1000, 1'b0, 4'hF, 32'h0, 4'd3);
    @(negedge clk);
    check("load_req", 64'(data_req_o), 64'd1);
    check("load_addr", 64'(data_addr_o), 64'h1000);
    check("load_we", 64'(data_we_o), 64'd0);
    @(negedge clk);
    check("load_req_one_cycle", 64'(data_req_o), 64'd0);
    respond(32'hDEADBEEF, 1'b0, 4'd3);
    idle(3);

    // Store with grant held off for four cycles.
    gnt_en = 1'b0;
    issue(32'h2004, 1'b1, 4'hF, 32'h12345678, 4'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("st_req", 64'(data_req_o), 64'd1);
      check("st_bus", {data_addr_o, data_we_o, data_be_o}, {32'h2004, 1'b1, 4'hF});
      check("st_wdata", 64'(data_wdata_o), 64'h12345678);
      check("st_ready", 64'(x_mem_ready_o), 64'd0);
      if (i == 3) begin
        #1 gnt_en = 1'b1;
      end
    end
    @(negedge clk);
    check("st_req_dropped", 64'(data_req_o), 64'd0);
    respond(32'hCAFEF00D, 1'b0, 4'd6);
    idle(3);

    // Fill both outstanding slots, third request must wait for a pop.
    issue(32'h3000, 1'b0, 4'hF, 32'h0, 4'd1);
    issue(32'h3004, 1'b0, 4'hF, 32'h0, 4'd2);
    idle(1);
    x_mem_req_addr_i = 32'h3008; x_mem_req_we_i = 1'b0; x_mem_req_id_i = 4'd3;
    x_mem_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready_low", 64'(x_mem_ready_o), 64'd0);
    end
    respond(32'h11111111, 1'b0, 4'd1);
    check("ready_after_pop", 64'(x_mem_ready_o), 64'd1);
    @(posedge clk);
    #1 x_mem_valid_i = 1'b0;
    idle(2);
    respond(32'h22222222, 1'b0, 4'd2);
    respond(32'h33333333, 1'b0, 4'd3);
    idle(3);

    // Grant of id 5 in the same cycle as the response for id 4.
    issue(32'h4000, 1'b0, 4'hF, 32'h0, 4'd4);
    idle(2);
    gnt_en = 1'b0;
    issue(32'h4004, 1'b0, 4'h3, 32'h0, 4'd5);
    @(negedge clk);
    check("sim_req", 64'(data_req_o), 64'd1);
    #1 gnt_en = 1'b1;
    respond(32'h44444444, 1'b0, 4'd4);
    check("sim_count", 64'(dut.fifo_count), 64'd1);
    check("sim_req_granted", 64'(data_req_o), 64'd0);
    respond(32'h55555555, 1'b0, 4'd5);
    idle(3);
    check("drained_count", 64'(dut.fifo_count), 64'd0);

    // Error response, then a clean access.
    issue(32'h5000, 1'b0, 4'hF, 32'h0, 4'd9);
    idle(2);
    respond(32'hBAD0BAD0, 1'b1, 4'd9);
    issue(32'h5004, 1'b0, 4'hF, 32'h0, 4'd10);
    idle(2);
    respond(32'h00C0FFEE, 1'b0, 4'd10);
    idle(3);

    // Reset during REQ with one id outstanding.
    issue(32'h6000, 1'b0, 4'hF, 32'h0, 4'd7);
    idle(2);
    gnt_en = 1'b0;
    issue(32'h6004, 1'b1, 4'hF, 32'hA5A5A5A5, 4'd8);
    @(negedge clk);
    check("mid_req", 64'(data_req_o), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_req", 64'(data_req_o), 64'd0);
    check("mid_rst_ready", 64'(x_mem_ready_o), 64'd0);
    check("mid_rst_bus", {data_addr_o, data_we_o, data_be_o, data_wdata_o[26:0]}, 64'd0);
    gnt_en = 1'b1;
    @(negedge clk);
    data_rvalid_i = 1'b1; data_rdata_i = 32'h77777777;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    #2 rst_ni = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(x_mem_ready_o), 64'd1);
    check("post_rst_count", 64'(dut.fifo_count), 64'd0);
    idle(4);
    issue(32'h7000, 1'b0, 4'hF, 32'h0, 4'd11);
    idle(2);
    respond(32'h0BADF00D, 1'b0, 4'd11);
    idle(4);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
